store_bus_monitor: RTL and testbench



---
 rtl/mips_dbg_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 45 ++++
 rtl/store_bus_monitor.sv | 117 +++++++++++
 tb/tb_store_bus_monitor.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_dbg_pkg.sv
// Shared types and helpers for the MIPS store-bus debug monitor.
package mips_dbg_pkg;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_BYTE = 2'b01;
  localparam logic [1:0] MW_HALF = 2'b10;
  localparam logic [1:0] MW_WORD = 2'b11;

  typedef enum logic [1:0] {RUN, DONE, TIMED_OUT} mon_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } log_entry_t;

  // Keep only the bytes the store actually writes; upper bits read as zero.
  function automatic logic [31:0] mask_store(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] res;
    case (size)
      MW_BYTE: res = {24'h0, data[7:0]};
      MW_HALF: res = {16'h0, data[15:0]};
      MW_WORD: res = data;
      default: res = 32'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers.
module sync_fifo #(
  parameter int unsigned WIDTH = 66,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_pop, do_push;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/store_bus_monitor.sv
// Logs CPU data stores into a drainable FIFO, decodes the pass/fail signature store
// and runs a watchdog so program tests terminate without an external checker.
module store_bus_monitor
  import mips_dbg_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] DONE_ADDR = 32'd88,
  parameter logic [31:0] TIMEOUT   = 32'd100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic [1:0]  log_size,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] store_count,
  output logic [15:0] drop_count
);

  mon_state_t  state_q, state_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] store_count_q, store_count_d;
  logic [15:0] drop_count_q, drop_count_d;
  logic        done_q, done_d, pass_q, pass_d, timeout_q, timeout_d;

  logic        accept, is_sig, wd_expire;
  logic        fifo_full, fifo_empty;
  logic [31:0] masked;
  log_entry_t  push_entry, head;

  assign masked     = mask_store(memwrite, writedata);
  assign accept     = (memwrite != MW_NONE) && (state_q == RUN);
  assign is_sig     = accept && (dataadr == DONE_ADDR);
  assign wd_expire  = (TIMEOUT != 32'd0) && (wd_q == TIMEOUT - 32'd1);
  assign push_entry = '{addr: dataadr, data: masked, size: memwrite};

  sync_fifo #(
    .WIDTH($bits(log_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (accept),
    .pop  (log_ready),
    .wdata(push_entry),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    wd_d          = wd_q;
    store_count_d = store_count_q;
    drop_count_d  = drop_count_q;
    done_d        = done_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    if (state_q == RUN) begin
      if (accept) begin
        store_count_d = store_count_q + 32'd1;
        // Full with a simultaneous pop still accepts the push.
        if (fifo_full && !log_ready && drop_count_q != 16'hFFFF) begin
          drop_count_d = drop_count_q + 16'd1;
        end
      end
      if (is_sig) begin
        done_d  = 1'b1;
        pass_d  = (masked == 32'd0);
        state_d = DONE;
      end else if (wd_expire) begin
        timeout_d = 1'b1;
        state_d   = TIMED_OUT;
      end else if (TIMEOUT != 32'd0) begin
        wd_d = wd_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      wd_q          <= '0;
      store_count_q <= '0;
      drop_count_q  <= '0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      store_count_q <= store_count_d;
      drop_count_q  <= drop_count_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
    end
  end

  assign log_valid   = ~fifo_empty;
  assign log_addr    = head.addr;
  assign log_data    = head.data;
  assign log_size    = head.size;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign store_count = store_count_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_store_bus_monitor.sv
// Self-checking bench for store_bus_monitor: vector table plus scoreboard of logged stores.
module tb_store_bus_monitor;

  localparam int unsigned DEPTH     = 16;
  localparam logic [31:0] DONE_ADDR = 32'd88;
  localparam logic [31:0] TO        = 32'd50;

  logic        clk, reset;
  logic [1:0]  memwrite;
  logic [31:0] dataadr, writedata;
  logic        log_valid, log_ready;
  logic [31:0] log_addr, log_data;
  logic [1:0]  log_size;
  logic        done, pass, timeout;
  logic [31:0] store_count;
  logic [15:0] drop_count;

  store_bus_monitor #(
    .DEPTH    (DEPTH),
    .DONE_ADDR(DONE_ADDR),
    .TIMEOUT  (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .memwrite   (memwrite),
    .dataadr    (dataadr),
    .writedata  (writedata),
    .log_valid  (log_valid),
    .log_ready  (log_ready),
    .log_addr   (log_addr),
    .log_data   (log_data),
    .log_size   (log_size),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout),
    .store_count(store_count),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } ent_t;

  typedef struct {
    logic [1:0]  mw;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Reference model state
  ent_t        exp_q[$];
  int          m_state;  // 0 run, 1 done, 2 timed out
  logic [31:0] m_wd, m_cnt;
  int          m_drop;
  logic        m_done, m_pass, m_to;

  function automatic logic [31:0] tb_mask(input logic [1:0] mw, input logic [31:0] d);
    if (mw == 2'b01) return {24'h0, d[7:0]};
    if (mw == 2'b10) return {16'h0, d[15:0]};
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_state = 0;
    m_wd    = 0;
    m_cnt   = 0;
    m_drop  = 0;
    m_done  = 0;
    m_pass  = 0;
    m_to    = 0;
  endtask

  task automatic compare_all();
    chk("log_valid", {31'h0, log_valid}, {31'h0, exp_q.size() > 0});
    chk("store_count", store_count, m_cnt);
    chk("drop_count", {16'h0, drop_count}, m_drop);
    chk("done", {31'h0, done}, {31'h0, m_done});
    chk("timeout", {31'h0, timeout}, {31'h0, m_to});
    if (m_done) chk("pass", {31'h0, pass}, {31'h0, m_pass});
  endtask

  // Advance one clock with the current inputs, updating the model and checking pops.
  task automatic tick();
    ent_t e;
    bit   sig;
    if (reset) begin
      @(posedge clk);
      #1;
      model_reset();
      compare_all();
      return;
    end
    if (exp_q.size() > 0 && log_ready) begin
      e = exp_q.pop_front();
      chk("head_addr", log_addr, e.addr);
      chk("head_data", log_data, e.data);
      chk("head_size", {30'h0, log_size}, {30'h0, e.size});
    end
    if (m_state == 0) begin
      sig = 0;
      if (memwrite != 2'b00) begin
        m_cnt = m_cnt + 1;
        if (exp_q.size() < DEPTH) begin
          e.addr = dataadr;
          e.data = tb_mask(memwrite, writedata);
          e.size = memwrite;
          exp_q.push_back(e);
        end else if (m_drop < 65535) begin
          m_drop++;
        end
        if (dataadr == DONE_ADDR) begin
          sig     = 1;
          m_done  = 1;
          m_pass  = (tb_mask(memwrite, writedata) == 0);
          m_state = 1;
        end
      end
      if (!sig && TO != 0) begin
        if (m_wd == TO - 1) begin
          m_to    = 1;
          m_state = 2;
        end else begin
          m_wd = m_wd + 1;
        end
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic [1:0] mw, input logic [31:0] adr, input logic [31:0] wd,
                       input logic rdy);
    memwrite  = mw;
    dataadr   = adr;
    writedata = wd;
    log_ready = rdy;
    tick();
    memwrite  = 2'b00;
  endtask

  task automatic idle(input logic rdy);
    drive(2'b00, 32'h0, 32'h0, rdy);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    memwrite = 2'b00;
    tick();
    reset    = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    vecs[0] = '{2'b11, 32'h54, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{2'b01, 32'h20, 32'h12345678, 32'h00000078};
    vecs[2] = '{2'b10, 32'h24, 32'hCAFEBABE, 32'h0000BABE};
    vecs[3] = '{2'b01, 32'h28, 32'hFFFFFF80, 32'h00000080};
    vecs[4] = '{2'b10, 32'h2C, 32'h0001FFFF, 32'h0000FFFF};
    vecs[5] = '{2'b11, 32'h04, 32'h00000000, 32'h00000000};

    reset = 1'b1; memwrite = 2'b00; dataadr = '0; writedata = '0; log_ready = 1'b0;

    // Reset state and table-driven masking with an always-ready sink.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].mw, vecs[i].adr, vecs[i].wd, 1'b1);
      chk("vec_valid", {31'h0, log_valid}, 32'd1);
      chk("vec_addr", log_addr, vecs[i].adr);
      chk("vec_data", log_data, vecs[i].exp);
      chk("vec_size", {30'h0, log_size}, {30'h0, vecs[i].mw});
      chk("vec_count", store_count, i + 1);
    end
    idle(1'b1);

    // Byte then halfword held back, then drained in order.
    do_reset();
    drive(2'b01, 32'h30, 32'h12345678, 1'b0);
    drive(2'b10, 32'h34, 32'hCAFEBABE, 1'b0);
    chk("order_head", log_data, 32'h78);
    idle(1'b1);
    chk("order_second", log_data, 32'hBABE);
    idle(1'b1);

    // Signature pass, later store ignored.
    do_reset();
    drive(2'b11, DONE_ADDR, 32'h0, 1'b1);
    chk("sig_done", {31'h0, done}, 32'd1);
    chk("sig_pass", {31'h0, pass}, 32'd1);
    drive(2'b11, 32'h10, 32'h55, 1'b1);
    chk("post_done_count", store_count, 32'd1);
    // Signature fail.
    do_reset();
    drive(2'b11, DONE_ADDR, 32'h7, 1'b1);
    chk("sig_fail_pass", {31'h0, pass}, 32'd0);
    // Byte signature whose masked data is zero still passes.
    do_reset();
    drive(2'b01, DONE_ADDR, 32'h00000100, 1'b1);
    chk("sig_byte_pass", {31'h0, pass}, 32'd1);

    // Overflow: 20 stores into a stalled FIFO, then push+pop while full.
    do_reset();
    for (int i = 0; i < 20; i++) drive(2'b11, 32'h100 + 4 * i, 32'hA000 + i, 1'b0);
    chk("ovf_drop", {16'h0, drop_count}, 32'd4);
    chk("ovf_count", store_count, 32'd20);
    drive(2'b11, 32'h200, 32'hBEEF, 1'b1);
    chk("full_pushpop_drop", {16'h0, drop_count}, 32'd4);
    n = 0;
    for (int i = 0; i < 40 && log_valid; i++) begin
      n++;
      idle(1'b1);
    end
    chk("occupancy", n, 32'd16);

    // Watchdog expires after exactly TO cycles in RUN.
    do_reset();
    for (int i = 0; i < 49; i++) idle(1'b0);
    chk("wd_before", {31'h0, timeout}, 32'd0);
    idle(1'b0);
    chk("wd_expired", {31'h0, timeout}, 32'd1);
    drive(2'b11, 32'h40, 32'h1, 1'b0);
    chk("wd_ignore_store", store_count, 32'd0);
    // Signature on the expiry cycle wins.
    do_reset();
    for (int i = 0; i < 49; i++) idle(1'b0);
    drive(2'b11, DONE_ADDR, 32'h0, 1'b1);
    chk("race_done", {31'h0, done}, 32'd1);
    chk("race_timeout", {31'h0, timeout}, 32'd0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Reset mid-operation clears queued entries and status.
    do_reset();
    for (int i = 0; i < 4; i++) drive(2'b10, 32'h60 + i, 32'h1111 * (i + 1), 1'b0);
    drive(2'b11, DONE_ADDR, 32'h3, 1'b0);
    chk("pre_reset_done", {31'h0, done}, 32'd1);
    do_reset();
    chk("rst_valid", {31'h0, log_valid}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_count", store_count, 32'd0);
    drive(2'b11, 32'h70, 32'h9, 1'b1);
    chk("rst_run_count", store_count, 32'd1);
    idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
